regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Stage-5 register file and write-back unit for the pipelined processor. It consumes the per-cycle load and enable strobes from the stage-4 control code generator: LRN, LR0 and ERN, qualified with the destination register index carried down the pipe. It owns R0 (accumulator) and R1–R7, serves registered operand reads to the decode stage, and drives the selected Rn onto the store/output bus. A busy scoreboard stalls decode while a register has an outstanding write-back in flight.

## Interface
- DATA_W, 8, register/data width
- NREG, 8, number of registers (R0 = accumulator)
- ADDR_W, 3, register index width (log2 NREG)
- clk  in  1  global clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lrn  in  1  load Rn: write wb_data into R[wb_rn]
- lr0  in  1  load R0: write alu_data into R0
- ern  in  1  enable Rn onto rn_bus (STA/PSH/OUT source)
- wb_rn  in  ADDR_W  destination/source register index from stage 4
- wb_data  in  DATA_W  memory/immediate/bus data for Rn loads
- alu_data  in  DATA_W  ALU result for R0
- rd_req  in  1  decode-stage operand read request
- rd_rn  in  ADDR_W  operand register index
- mark_en  in  1  decode issued an instruction that will write mark_rn
- mark_rn  in  ADDR_W  register to mark busy
- rd_data  out  DATA_W  registered operand, valid when rd_valid
- rd_valid  out  1  one-cycle pulse, read completed
- stall  out  1  combinational: rd_req blocked by a busy register
- rn_bus  out  DATA_W  registered Rn value for ern
- rn_bus_valid  out  1  one-cycle pulse following ern
- r0_out  out  DATA_W  current R0 contents, to the ALU

## Operation
- Reset: R0–R7 = 0, busy = 0, rd_data = 0, rd_valid = 0, rn_bus = 0, rn_bus_valid = 0, r0_out = 0, stall = 0.
- Writes: lrn writes R[wb_rn] <= wb_data, and lr0 writes R0 <= alu_data.
  - If lrn and lr0 are both set with wb_rn == 0, lr0 wins.
  - If lrn and lr0 are both set with wb_rn != 0, both writes occur.
- Scoreboard:
  - mark_en sets busy[mark_rn].
  - lrn clears busy[wb_rn], and lr0 clears busy[0].
  - If a set and a clear hit the same register in the same cycle, the set wins.
- stall = rd_req && busy[rd_rn], subject to the bypass exception in Configuration.
- Read: when rd_req && !stall, rd_data <= R[rd_rn] and rd_valid pulses on the next cycle.
  - While stalled, rd_valid = 0 and rd_data holds its value.
  - Decode holds rd_req and rd_rn stable until the read is accepted.
- ern: rn_bus <= R[wb_rn] and rn_bus_valid pulses on the next cycle. This takes the pre-write value unless bypassed.
- A read of an unwritten register returns 0. Indices are always in range; no wrap behaviour applies.

## Timing
- Write latency 1: a write at edge N is visible in r0_out and in array reads after edge N.
- Read latency 1 from an accepted rd_req.
- stall is combinational within the cycle and never registered.
- A busy bit set at edge N can raise stall from cycle N+1.
- Reset asserted mid-operation clears all state immediately. The first post-reset edge behaves as a fresh start.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read or ern whose register is being written in the same cycle returns the incoming write data, using lr0 data for R0 under the collision rule.
  - stall is suppressed when the busy register is cleared in that same cycle.
- Undefined: reads and ern see the old array contents. stall persists until the cleared busy bit is registered, one cycle later than with bypass.

## Structure
- Shared package anppv_pkg holds DATA_W, ADDR_W, NREG and the R0_IDX = 0 constant.
- One sub-module, wb_scoreboard, holds the NREG busy bits with set/clear/set-wins logic. It exposes busy[rd_rn] and the same-cycle clear match used for bypass.
- The top level holds the register array, the read and rn_bus registers, and the bypass muxing.

## Test plan
- Reset, then rd_req on R3: rd_data = 0x00 and rd_valid pulses 1 cycle later; r0_out = 0x00.
- lrn with wb_rn = 5, wb_data = 0xA7; next cycle rd_req rd_rn = 5 -> rd_data = 0xA7.
- lrn and lr0 together with wb_rn = 0, wb_data = 0x11, alu_data = 0x22 -> r0_out = 0x22.
- mark_en on R2, then rd_req R2 -> stall = 1.
  - lrn wb_rn = 2 with wb_data = 0x3C arrives 3 cycles later.
  - With bypass: rd_data = 0x3C that same cycle, stall drops.
  - Without bypass: stall drops one cycle later, rd_data = 0x3C.
- R4 = 0x55, then ern with wb_rn = 4 and simultaneous lrn writing 0x66 -> rn_bus = 0x66 with bypass, 0x55 without.
- mark_en on R6 in the same cycle lrn clears R6 -> busy[6] stays 1, so rd_req R6 stalls.
- rst_n pulsed low during a stalled read -> all outputs 0 and busy cleared; the re-issued read completes with no stall.

Source files
------------

// File: rtl/anppv_pkg.sv
// Shared processor constants: data/index widths, register count and the accumulator index.
package anppv_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned R0_IDX = 0;
endpackage

// File: rtl/regfile_writeback_if.sv
// Stage-4/decode to register-file bus: write-back strobes, operand reads, scoreboard marks.
interface regfile_writeback_if;
    import anppv_pkg::*;

    logic              lrn;
    logic              lr0;
    logic              ern;
    logic [ADDR_W-1:0] wb_rn;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] alu_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_rn;
    logic              mark_en;
    logic [ADDR_W-1:0] mark_rn;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              stall;
    logic [DATA_W-1:0] rn_bus;
    logic              rn_bus_valid;
    logic [DATA_W-1:0] r0_out;

    modport master (
        output lrn, lr0, ern, wb_rn, wb_data, alu_data, rd_req, rd_rn, mark_en, mark_rn,
        input  rd_data, rd_valid, stall, rn_bus, rn_bus_valid, r0_out
    );

    modport slave (
        input  lrn, lr0, ern, wb_rn, wb_data, alu_data, rd_req, rd_rn, mark_en, mark_rn,
        output rd_data, rd_valid, stall, rn_bus, rn_bus_valid, r0_out
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Busy bit per register: set by decode issue, cleared by write-back, set wins on collision.
module wb_scoreboard
    import anppv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_rn,
    input  logic              lrn,
    input  logic              lr0,
    input  logic [ADDR_W-1:0] wb_rn,
    input  logic [ADDR_W-1:0] rd_rn,
    output logic              rd_busy_c,
    output logic              rd_clr_c
);
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (mark_en) set_vec[mark_rn] = 1'b1;
        if (lrn)     clr_vec[wb_rn] = 1'b1;
        if (lr0)     clr_vec[ADDR_W'(R0_IDX)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= set_vec | (busy & ~clr_vec);
    end

    assign rd_busy_c = busy[rd_rn];
    assign rd_clr_c  = clr_vec[rd_rn];
endmodule

// File: rtl/regfile_writeback.sv
// Stage-5 register file R0..R7 with write-back, registered operand reads and the Rn output bus.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads/ern and release stall early.
module regfile_writeback
    import anppv_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    regfile_writeback_if.slave bus
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] R0_RN = ADDR_W'(R0_IDX);

    logic [DATA_W-1:0] regs [NREG];
    logic              rd_busy_c;
    logic              rd_clr_c;
    logic              rd_accept_c;
    logic [DATA_W-1:0] rd_src_c;
    logic [DATA_W-1:0] ern_src_c;

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .mark_en   (bus.mark_en),
        .mark_rn   (bus.mark_rn),
        .lrn       (bus.lrn),
        .lr0       (bus.lr0),
        .wb_rn     (bus.wb_rn),
        .rd_rn     (bus.rd_rn),
        .rd_busy_c (rd_busy_c),
        .rd_clr_c  (rd_clr_c)
    );

    assign bus.stall   = bus.rd_req && rd_busy_c && !(BYPASS && rd_clr_c);
    assign rd_accept_c = bus.rd_req && !bus.stall;
    assign bus.r0_out  = regs[R0_RN];

    // Source selection; forwarding follows the write collision rule (lr0 owns R0).
    always_comb begin
        rd_src_c  = regs[bus.rd_rn];
        ern_src_c = regs[bus.wb_rn];
        if (BYPASS) begin
            if (bus.lr0 && bus.rd_rn == R0_RN)
                rd_src_c = bus.alu_data;
            else if (bus.lrn && bus.wb_rn == bus.rd_rn)
                rd_src_c = bus.wb_data;
            if (bus.lr0 && bus.wb_rn == R0_RN)
                ern_src_c = bus.alu_data;
            else if (bus.lrn)
                ern_src_c = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (bus.lr0 && i == R0_IDX)
                    regs[i] <= bus.alu_data;
                else if (bus.lrn && bus.wb_rn == ADDR_W'(i))
                    regs[i] <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data      <= '0;
            bus.rd_valid     <= 1'b0;
            bus.rn_bus       <= '0;
            bus.rn_bus_valid <= 1'b0;
        end else begin
            bus.rd_valid     <= rd_accept_c;
            bus.rn_bus_valid <= bus.ern;
            if (rd_accept_c) bus.rd_data <= rd_src_c;
            if (bus.ern)     bus.rn_bus  <= ern_src_c;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_writeback;
    import anppv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    regfile_writeback_if bus ();

    regfile_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.lrn = 1'b0; bus.lr0 = 1'b0; bus.ern = 1'b0;
        bus.wb_rn = '0; bus.wb_data = '0; bus.alu_data = '0;
        bus.rd_req = 1'b0; bus.rd_rn = '0;
        bus.mark_en = 1'b0; bus.mark_rn = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},  32'(bus.rd_data), 32'h0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
        check({tag, "_rn_bus"},   32'(bus.rn_bus), 32'h0);
        check({tag, "_rn_valid"}, 32'(bus.rn_bus_valid), 32'h0);
        check({tag, "_r0_out"},   32'(bus.r0_out), 32'h0);
        check({tag, "_stall"},    32'(bus.stall), 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // Fresh read of an unwritten register
        bus.rd_req = 1'b1; bus.rd_rn = 3'd3;
        #1 check("r3_stall", 32'(bus.stall), 32'h0);
        tick(); bus.rd_req = 1'b0;
        check("r3_valid", 32'(bus.rd_valid), 32'h1);
        check("r3_data", 32'(bus.rd_data), 32'h0);
        check("r3_r0_out", 32'(bus.r0_out), 32'h0);
        tick();
        check("r3_valid_pulse", 32'(bus.rd_valid), 32'h0);

        // Rn load then read back
        bus.lrn = 1'b1; bus.wb_rn = 3'd5; bus.wb_data = 8'hA7;
        tick(); bus.lrn = 1'b0; bus.rd_req = 1'b1; bus.rd_rn = 3'd5;
        tick(); bus.rd_req = 1'b0;
        check("r5_data", 32'(bus.rd_data), 32'hA7);
        check("r5_valid", 32'(bus.rd_valid), 32'h1);

        // lrn and lr0 both on R0: lr0 wins
        bus.lrn = 1'b1; bus.lr0 = 1'b1; bus.wb_rn = 3'd0; bus.wb_data = 8'h11; bus.alu_data = 8'h22;
        tick();
        check("r0_collide", 32'(bus.r0_out), 32'h22);

        // lrn on R1 and lr0 together: both land
        bus.wb_rn = 3'd1; bus.wb_data = 8'h33; bus.alu_data = 8'h44;
        tick(); bus.lrn = 1'b0; bus.lr0 = 1'b0;
        check("dual_r0", 32'(bus.r0_out), 32'h44);
        bus.rd_req = 1'b1; bus.rd_rn = 3'd1;
        tick(); bus.rd_req = 1'b0;
        check("dual_r1", 32'(bus.rd_data), 32'h33);

        // Scoreboard stall on R2, released by write-back
        bus.mark_en = 1'b1; bus.mark_rn = 3'd2;
        tick(); bus.mark_en = 1'b0; bus.rd_req = 1'b1; bus.rd_rn = 3'd2;
        #1 check("r2_stall_a", 32'(bus.stall), 32'h1);
        tick();
        check("r2_hold_valid", 32'(bus.rd_valid), 32'h0);
        check("r2_hold_data", 32'(bus.rd_data), 32'h33);
        #1 check("r2_stall_b", 32'(bus.stall), 32'h1);
        tick();
        check("r2_hold_valid_b", 32'(bus.rd_valid), 32'h0);
        bus.lrn = 1'b1; bus.wb_rn = 3'd2; bus.wb_data = 8'h3C;
        #1 check("r2_stall_wb", 32'(bus.stall), BYP ? 32'h0 : 32'h1);
        tick(); bus.lrn = 1'b0;
        if (!BYP) begin
            check("r2_late_valid", 32'(bus.rd_valid), 32'h0);
            #1 check("r2_stall_late", 32'(bus.stall), 32'h0);
            tick();
        end
        bus.rd_req = 1'b0;
        check("r2_valid", 32'(bus.rd_valid), 32'h1);
        check("r2_data", 32'(bus.rd_data), 32'h3C);

        // ern on R4 with a same-cycle write
        bus.lrn = 1'b1; bus.wb_rn = 3'd4; bus.wb_data = 8'h55;
        tick(); bus.ern = 1'b1; bus.wb_data = 8'h66;
        tick(); bus.ern = 1'b0; bus.lrn = 1'b0;
        check("r4_rn_bus", 32'(bus.rn_bus), BYP ? 32'h66 : 32'h55);
        check("r4_rn_valid", 32'(bus.rn_bus_valid), 32'h1);
        tick();
        check("r4_rn_valid_pulse", 32'(bus.rn_bus_valid), 32'h0);
        bus.ern = 1'b1; bus.wb_rn = 3'd4;
        tick(); bus.ern = 1'b0;
        check("r4_rn_bus_after", 32'(bus.rn_bus), 32'h66);

        // ern on R0 while lrn and lr0 collide there
        bus.ern = 1'b1; bus.lrn = 1'b1; bus.lr0 = 1'b1; bus.wb_rn = 3'd0;
        bus.wb_data = 8'h99; bus.alu_data = 8'h77;
        tick(); idle();
        check("r0_rn_bus", 32'(bus.rn_bus), BYP ? 32'h77 : 32'h44);
        check("r0_after_ern", 32'(bus.r0_out), 32'h77);

        // Mark and clear R6 together: set wins
        bus.mark_en = 1'b1; bus.mark_rn = 3'd6; bus.lrn = 1'b1; bus.wb_rn = 3'd6; bus.wb_data = 8'h12;
        tick(); idle(); bus.rd_req = 1'b1; bus.rd_rn = 3'd6;
        #1 check("r6_stall", 32'(bus.stall), 32'h1);
        tick();
        check("r6_hold_valid", 32'(bus.rd_valid), 32'h0);
        #1 check("r6_stall_b", 32'(bus.stall), 32'h1);

        // Reset in the middle of the stalled read
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        tick(); rst_n = 1'b1;
        #1 check("rerd_stall", 32'(bus.stall), 32'h0);
        tick(); bus.rd_req = 1'b0;
        check("rerd_valid", 32'(bus.rd_valid), 32'h1);
        check("rerd_data", 32'(bus.rd_data), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
